// File: rtl/if_rx_dispatch.sv
// Receive-side dispatcher: opens one reader transfer per scheduler request, then
// routes each received word to the config registers or the buffer chosen by the code.
module if_rx_dispatch #(
  parameter int SPI_WIDTH  = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int CFG_REGS   = 4,
  parameter logic [3:0] IFCODE_CFG    = 4'd0,
  parameter logic [3:0] IFCODE_ACT    = 4'd1,
  parameter logic [3:0] IFCODE_FLGACT = 4'd2,
  parameter logic [3:0] IFCODE_WEI    = 4'd3,
  parameter logic [3:0] IFCODE_FLGWEI = 4'd4
) (
  input  logic                           clk_chip,
  input  logic                           reset_n_chip,
  input  logic                           req_valid,
  input  logic [3:0]                     req_code,
  output logic                           req_ready,
  input  logic                           config_ready,
  output logic                           config_paulse,
  output logic [3:0]                     config_data,
  output logic                           rd_req,
  input  logic                           rd_valid,
  input  logic [SPI_WIDTH-1:0]           rd_data,
  input  logic                           rd_done,
  input  logic                           buf_full,
  output logic [3:0]                     buf_wr_en,
  output logic [ADDR_WIDTH-1:0]          buf_wr_addr,
  output logic [SPI_WIDTH-1:0]           buf_wr_data,
  output logic [CFG_REGS*SPI_WIDTH-1:0]  cfg_regs,
  output logic                           xfer_done,
  output logic [3:0]                     xfer_code,
  input  logic                           err_clr,
  output logic [2:0]                     err_flags
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_RECV,
    S_DONE
  } state_t;

  state_t                state;
  logic [3:0]            code_q;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [3:0]            wr_sel;
  logic                  is_cfg;
  logic                  code_known;
  logic                  cfg_full;
  logic                  accept;
  logic [2:0]            err_set;

  always_comb begin
    wr_sel = 4'b0000;
    is_cfg = 1'b0;
    case (code_q)
      IFCODE_ACT:    wr_sel = 4'b0001;
      IFCODE_FLGACT: wr_sel = 4'b0010;
      IFCODE_WEI:    wr_sel = 4'b0100;
      IFCODE_FLGWEI: wr_sel = 4'b1000;
      IFCODE_CFG:    is_cfg = 1'b1;
      default:       ;
    endcase
  end

  assign code_known = is_cfg | (|wr_sel);
  // For config transfers the counter stops at CFG_REGS, so every later word is an overflow.
  assign cfg_full   = (cnt >= ADDR_WIDTH'(CFG_REGS));
  assign accept     = (state == S_RECV) && rd_valid;

  assign err_set[0] = (state == S_ISSUE) && !code_known;
  assign err_set[1] = accept && (|wr_sel) && (cnt == '1);
  assign err_set[2] = accept && is_cfg && cfg_full;

  assign req_ready = (state == S_IDLE);
  assign rd_req    = (state == S_RECV) && !buf_full;

  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) begin
      state         <= S_IDLE;
      code_q        <= '0;
      cnt           <= '0;
      config_paulse <= 1'b0;
      config_data   <= '0;
      buf_wr_en     <= '0;
      buf_wr_addr   <= '0;
      buf_wr_data   <= '0;
      cfg_regs      <= '0;
      xfer_done     <= 1'b0;
      xfer_code     <= '0;
      err_flags     <= '0;
    end else begin
      config_paulse <= 1'b0;
      xfer_done     <= 1'b0;
      buf_wr_en     <= '0;
      // A new error in the same cycle as err_clr survives the clear.
      err_flags     <= (err_clr ? 3'b000 : err_flags) | err_set;
      case (state)
        S_IDLE: begin
          if (req_valid && config_ready) begin
            code_q        <= req_code;
            config_data   <= req_code;
            config_paulse <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (!config_ready) state <= S_RECV;
        end
        S_RECV: begin
          if (rd_valid) begin
            if (|wr_sel) begin
              buf_wr_en   <= wr_sel;
              buf_wr_addr <= cnt;
              buf_wr_data <= rd_data;
              cnt         <= cnt + 1'b1;
            end else if (is_cfg && !cfg_full) begin
              for (int i = 0; i < CFG_REGS; i++) begin
                if (cnt == ADDR_WIDTH'(i)) cfg_regs[i*SPI_WIDTH +: SPI_WIDTH] <= rd_data;
              end
              cnt <= cnt + 1'b1;
            end
          end
          if (rd_done) begin
            xfer_done <= 1'b1;
            xfer_code <= code_q;
            state     <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_rx_dispatch.sv
// Bench for if_rx_dispatch: a behavioural reader feeds transfers, a negedge monitor
// checks buffer writes, open pulses and completions against expected queues.
module tb_if_rx_dispatch;

  localparam logic [3:0] C_CFG = 4'd0, C_ACT = 4'd1, C_FLGACT = 4'd2;
  localparam logic [3:0] C_WEI = 4'd3, C_FLGWEI = 4'd4, C_BAD = 4'hF;

  // clock / reset
  logic clk_chip = 1'b0;
  logic reset_n_chip = 1'b0;
  always #5 clk_chip = ~clk_chip;

  logic        req_valid = 0, config_ready = 1, rd_valid = 0, rd_done = 0;
  logic        buf_full = 0, err_clr = 0, sel_w = 0;
  logic [3:0]  req_code = 0;
  logic [31:0] rd_data = 0;

  logic         m_req_ready, m_config_paulse, m_rd_req, m_xfer_done;
  logic [3:0]   m_config_data, m_buf_wr_en, m_xfer_code;
  logic [11:0]  m_buf_wr_addr;
  logic [31:0]  m_buf_wr_data;
  logic [127:0] cfg_regs, w_cfg_regs;
  logic [2:0]   m_err_flags;
  logic         w_req_ready, w_config_paulse, w_rd_req, w_xfer_done;
  logic [3:0]   w_config_data, w_buf_wr_en, w_xfer_code;
  logic [2:0]   w_buf_wr_addr;
  logic [31:0]  w_buf_wr_data;
  logic [2:0]   w_err_flags;

  logic         req_ready, config_paulse, rd_req, xfer_done;
  logic [3:0]   config_data, buf_wr_en, xfer_code;
  logic [11:0]  buf_wr_addr;
  logic [31:0]  buf_wr_data;
  logic [2:0]   err_flags;

  if_rx_dispatch dut (
    .clk_chip(clk_chip), .reset_n_chip(reset_n_chip),
    .req_valid(req_valid & ~sel_w), .req_code(req_code), .req_ready(m_req_ready),
    .config_ready(config_ready), .config_paulse(m_config_paulse), .config_data(m_config_data),
    .rd_req(m_rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
    .buf_full(buf_full), .buf_wr_en(m_buf_wr_en), .buf_wr_addr(m_buf_wr_addr),
    .buf_wr_data(m_buf_wr_data), .cfg_regs(cfg_regs), .xfer_done(m_xfer_done),
    .xfer_code(m_xfer_code), .err_clr(err_clr), .err_flags(m_err_flags)
  );

  if_rx_dispatch #(.ADDR_WIDTH(3)) dut_w (
    .clk_chip(clk_chip), .reset_n_chip(reset_n_chip),
    .req_valid(req_valid & sel_w), .req_code(req_code), .req_ready(w_req_ready),
    .config_ready(config_ready), .config_paulse(w_config_paulse), .config_data(w_config_data),
    .rd_req(w_rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
    .buf_full(buf_full), .buf_wr_en(w_buf_wr_en), .buf_wr_addr(w_buf_wr_addr),
    .buf_wr_data(w_buf_wr_data), .cfg_regs(w_cfg_regs), .xfer_done(w_xfer_done),
    .xfer_code(w_xfer_code), .err_clr(err_clr), .err_flags(w_err_flags)
  );

  assign req_ready     = sel_w ? w_req_ready     : m_req_ready;
  assign config_paulse = sel_w ? w_config_paulse : m_config_paulse;
  assign config_data   = sel_w ? w_config_data   : m_config_data;
  assign rd_req        = sel_w ? w_rd_req        : m_rd_req;
  assign buf_wr_en     = sel_w ? w_buf_wr_en     : m_buf_wr_en;
  assign buf_wr_addr   = sel_w ? {9'd0, w_buf_wr_addr} : m_buf_wr_addr;
  assign buf_wr_data   = sel_w ? w_buf_wr_data   : m_buf_wr_data;
  assign xfer_done     = sel_w ? w_xfer_done     : m_xfer_done;
  assign xfer_code     = sel_w ? w_xfer_code     : m_xfer_code;
  assign err_flags     = sel_w ? w_err_flags     : m_err_flags;

  // scoreboard
  logic [47:0] exp_q[$];
  logic [3:0]  exp_cfg_q[$];
  logic [3:0]  exp_done_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_chip) begin : monitor
    logic [47:0] e;
    if (reset_n_chip) begin
      if (buf_wr_en != 4'b0000) begin
        if (exp_q.size() == 0) chk("unexpected buf write", {buf_wr_en, buf_wr_addr, buf_wr_data}, 48'd0);
        else begin
          e = exp_q.pop_front();
          chk("buf write {en,addr,data}", {buf_wr_en, buf_wr_addr, buf_wr_data}, e);
        end
      end
      if (config_paulse) begin
        if (exp_cfg_q.size() == 0) chk("unexpected config_paulse", config_paulse, 1'b0);
        else chk("config_data at open", config_data, exp_cfg_q.pop_front());
      end
      if (xfer_done) begin
        if (exp_done_q.size() == 0) chk("unexpected xfer_done", xfer_done, 1'b0);
        else chk("xfer_code at done", xfer_code, exp_done_q.pop_front());
      end
    end
  end

  // driver: scheduler request plus a reader with one cycle of read latency
  task automatic do_xfer(input logic [3:0] code, input int n, input logic [31:0] base,
                         input int stall_lo, input int stall_hi, input int busy, input int abort);
    int sent, issued, wait_c;
    logic pend;
    logic [3:0] en;
    en = (code == C_ACT) ? 4'b0001 : (code == C_FLGACT) ? 4'b0010 :
         (code == C_WEI) ? 4'b0100 : (code == C_FLGWEI) ? 4'b1000 : 4'b0000;
    exp_cfg_q.push_back(code);
    for (int i = 0; i < n && i < abort; i++)
      if (en != 4'b0000) exp_q.push_back({en, sel_w ? 12'(i % 8) : 12'(i), base + 32'(i)});
    if (abort >= n) exp_done_q.push_back(code);

    @(negedge clk_chip);
    req_valid = 1; req_code = code; config_ready = (busy == 0);
    for (int k = 0; k < busy; k++) begin
      @(negedge clk_chip);
      chk("no open while reader busy", config_paulse, 1'b0);
      chk("req_ready while waiting", req_ready, 1'b1);
    end
    config_ready = 1;
    wait_c = 0;
    while (!config_paulse && wait_c < 20) begin
      @(negedge clk_chip);
      wait_c++;
    end
    if (!config_paulse) begin
      chk("config_paulse timeout", config_paulse, 1'b1);
      req_valid = 0;
      return;
    end
    req_valid = 0; config_ready = 0;
    @(negedge clk_chip);
    sent = 0; issued = 0; pend = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_chip);
      if (sent == n || sent == abort) begin
        rd_valid = 0; rd_done = 0;
        break;
      end
      if (pend) begin
        rd_valid = 1; rd_data = base + 32'(sent); sent++; rd_done = (sent == n);
      end else begin
        rd_valid = 0; rd_done = 0;
      end
      pend = 0;
      buf_full = (c >= stall_lo && c <= stall_hi);
      #1;
      if (buf_full) chk("rd_req low while buf_full", rd_req, 1'b0);
      if (rd_req && issued < n && issued < abort) begin
        pend = 1; issued++;
      end
    end
    buf_full = 0; rd_valid = 0; rd_done = 0;
    if (sent < n && sent < abort) chk("transfer word count", sent, n);
    if (abort < n) return;
    config_ready = 1;
    @(negedge clk_chip);
    chk("req_ready after done", req_ready, 1'b1);
  endtask

  task automatic clear_err();
    @(negedge clk_chip);
    err_clr = 1;
    @(negedge clk_chip);
    err_clr = 0;
    chk("err_flags after clear", err_flags, 3'b000);
  endtask

  task automatic chk_reset_outputs();
    chk("outputs at reset", {config_paulse, config_data, rd_req, buf_wr_en, buf_wr_addr,
                             buf_wr_data, xfer_done, xfer_code, err_flags}, 62'd0);
    chk("cfg_regs at reset", cfg_regs, 128'd0);
    chk("req_ready in IDLE", req_ready, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk_chip);
    chk_reset_outputs();
    reset_n_chip = 1;

    do_xfer(C_WEI, 8, 32'h100, 1000, 0, 0, 1000);
    chk("config_data holds code", config_data, C_WEI);

    do_xfer(C_CFG, 4, 32'hA0, 1000, 0, 0, 1000);
    chk("cfg_regs after 4 words", cfg_regs, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("err_flags after cfg 4", err_flags, 3'b000);

    do_xfer(C_CFG, 6, 32'hB0, 1000, 0, 0, 1000);
    chk("cfg_regs after 6 words", cfg_regs, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    chk("cfg overflow flag", err_flags, 3'b100);
    clear_err();

    do_xfer(C_ACT, 16, 32'h200, 3, 6, 0, 1000);
    do_xfer(C_FLGACT, 3, 32'h400, 1000, 0, 4, 1000);
    do_xfer(C_FLGWEI, 3, 32'h500, 1000, 0, 0, 1000);

    do_xfer(C_BAD, 2, 32'h600, 1000, 0, 0, 1000);
    chk("unknown code flag", err_flags, 3'b001);
    clear_err();

    @(negedge clk_chip);
    sel_w = 1;
    do_xfer(C_FLGWEI, 10, 32'h700, 1000, 0, 0, 1000);
    chk("address wrap flag", err_flags, 3'b010);
    clear_err();
    @(negedge clk_chip);
    sel_w = 0;

    do_xfer(C_CFG, 16, 32'hC0, 1000, 0, 0, 3);
    chk("cfg_regs mid-transfer", cfg_regs, {32'hB3, 32'hC2, 32'hC1, 32'hC0});
    #2 reset_n_chip = 0;
    #1 chk_reset_outputs();
    config_ready = 1;
    @(negedge clk_chip);
    reset_n_chip = 1;
    do_xfer(C_WEI, 2, 32'h800, 1000, 0, 0, 1000);

    @(negedge clk_chip);
    chk("writes left unseen", exp_q.size(), 0);
    chk("opens left unseen", exp_cfg_q.size(), 0);
    chk("completions left unseen", exp_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
